// File: rtl/lsu_bus_adapter.sv
// ----------------------------------------------------------------------------
// lsu_bus_adapter
//
// Load/store front end between the multicycle core and the memory bus. One
// request is accepted at a time (only while idle). The adapter checks it for
// illegal funct3 and misalignment. It then drives a word-aligned bus access
// with byte enables and lane-replicated store data, and waits for bus_ack.
// It returns sign/zero-extended load data, or an error indication.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_write             1 = store, 0 = load
//   req_funct3            RV32I load/store funct3
//   req_addr, req_wdata   byte address and store data (rs2)
//   resp_valid            one-cycle response strobe
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_misaligned       address not aligned to the access size
//   resp_fault            illegal funct3 or bus timeout
//   bus_addr              word address
//   bus_data_out          store data replicated across byte lanes
//   bus_byteen            byte-lane enables
//   bus_mem_read/_write   access strobes, held for the whole bus phase
//   bus_data_in, bus_ack  read data and completion from the bus
// ----------------------------------------------------------------------------
module lsu_bus_adapter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_misaligned,
    output logic             resp_fault,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_data_out,
    output logic [3:0]       bus_byteen,
    output logic             bus_mem_read,
    output logic             bus_mem_write,
    input  logic [WIDTH-1:0] bus_data_in,
    input  logic             bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last BUS-state counter value before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic             write_reg, write_next;
    logic [2:0]       funct3_reg, funct3_next;
    logic [1:0]       addr_lo_reg, addr_lo_next;
    logic [7:0]       cnt_reg, cnt_next;

    logic [WIDTH-1:0] bus_addr_reg, bus_addr_next;
    logic [WIDTH-1:0] bus_data_reg, bus_data_next;
    logic [3:0]       bus_byteen_reg, bus_byteen_next;
    logic             bus_rd_reg, bus_rd_next;
    logic             bus_wr_reg, bus_wr_next;

    logic             resp_valid_reg, resp_valid_next;
    logic [WIDTH-1:0] resp_rdata_reg, resp_rdata_next;
    logic             resp_mis_reg, resp_mis_next;
    logic             resp_fault_reg, resp_fault_next;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the live request while idle)
    // ------------------------------------------------------------------
    logic [1:0]       req_size;
    logic             req_illegal;
    logic             req_misaligned;
    logic [3:0]       req_byteen;
    logic [WIDTH-1:0] req_lane_data;

    assign req_size = req_funct3[1:0];

    always_comb begin
        req_illegal = 1'b0;
        if (req_write) begin
            // Stores: only SB/SH/SW exist.
            req_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
        end
    end

    assign req_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                            ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        req_byteen = 4'b1111;
        case (req_size)
            2'b00:   req_byteen = 4'b0001 << req_addr[1:0];
            2'b01:   req_byteen = 4'b0011 << req_addr[1:0];
            default: req_byteen = 4'b1111;
        endcase
    end

    // Store data replication: every lane carries the byte that would land
    // there for the given access size, so the bus can use byteen alone.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_lane_data[8*gi +: 8] =
                (req_size == 2'b00) ? req_wdata[7:0] :
                (req_size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                      req_wdata[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load extension from the live bus data, captured on bus_ack
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] load_shifted;
    logic [WIDTH-1:0] load_ext;

    assign load_shifted = bus_data_in >> {addr_lo_reg, 3'b000};

    always_comb begin
        load_ext = load_shifted;
        case (funct3_reg)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_ext = {24'd0, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b101:  load_ext = {16'd0, load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            write_reg      <= 1'b0;
            funct3_reg     <= 3'd0;
            addr_lo_reg    <= 2'd0;
            cnt_reg        <= 8'd0;
            bus_addr_reg   <= '0;
            bus_data_reg   <= '0;
            bus_byteen_reg <= 4'd0;
            bus_rd_reg     <= 1'b0;
            bus_wr_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_mis_reg   <= 1'b0;
            resp_fault_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            write_reg      <= write_next;
            funct3_reg     <= funct3_next;
            addr_lo_reg    <= addr_lo_next;
            cnt_reg        <= cnt_next;
            bus_addr_reg   <= bus_addr_next;
            bus_data_reg   <= bus_data_next;
            bus_byteen_reg <= bus_byteen_next;
            bus_rd_reg     <= bus_rd_next;
            bus_wr_reg     <= bus_wr_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_mis_reg   <= resp_mis_next;
            resp_fault_reg <= resp_fault_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        write_next      = write_reg;
        funct3_next     = funct3_reg;
        addr_lo_next    = addr_lo_reg;
        cnt_next        = cnt_reg;
        bus_addr_next   = bus_addr_reg;
        bus_data_next   = bus_data_reg;
        bus_byteen_next = bus_byteen_reg;
        bus_rd_next     = bus_rd_reg;
        bus_wr_next     = bus_wr_reg;
        resp_valid_next = resp_valid_reg;
        resp_rdata_next = resp_rdata_reg;
        resp_mis_next   = resp_mis_reg;
        resp_fault_next = resp_fault_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    write_next   = req_write;
                    funct3_next  = req_funct3;
                    addr_lo_next = req_addr[1:0];
                    cnt_next     = 8'd0;
                    if (req_illegal) begin
                        // Fault wins over misalignment.
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_rdata_next = '0;
                        resp_fault_next = 1'b1;
                        resp_mis_next   = 1'b0;
                    end else if (req_misaligned) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_rdata_next = '0;
                        resp_fault_next = 1'b0;
                        resp_mis_next   = 1'b1;
                    end else begin
                        state_next      = BUS;
                        bus_addr_next   = {req_addr[WIDTH-1:2], 2'b00};
                        bus_data_next   = req_lane_data;
                        bus_byteen_next = req_byteen;
                        bus_rd_next     = ~req_write;
                        bus_wr_next     = req_write;
                    end
                end
            end

            BUS: begin
                if (bus_ack || (cnt_reg == TO_LAST)) begin
                    state_next      = RESP;
                    bus_addr_next   = '0;
                    bus_data_next   = '0;
                    bus_byteen_next = 4'd0;
                    bus_rd_next     = 1'b0;
                    bus_wr_next     = 1'b0;
                    resp_valid_next = 1'b1;
                    resp_mis_next   = 1'b0;
                    if (bus_ack) begin
                        resp_fault_next = 1'b0;
                        resp_rdata_next = write_reg ? '0 : load_ext;
                    end else begin
                        resp_fault_next = 1'b1;
                        resp_rdata_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

            RESP: begin
                state_next      = IDLE;
                resp_valid_next = 1'b0;
                resp_rdata_next = '0;
                resp_mis_next   = 1'b0;
                resp_fault_next = 1'b0;
            end

            default: begin
                state_next      = IDLE;
                bus_addr_next   = '0;
                bus_data_next   = '0;
                bus_byteen_next = 4'd0;
                bus_rd_next     = 1'b0;
                bus_wr_next     = 1'b0;
                resp_valid_next = 1'b0;
                resp_rdata_next = '0;
                resp_mis_next   = 1'b0;
                resp_fault_next = 1'b0;
            end
        endcase
    end

    assign req_ready       = (state_reg == IDLE);
    assign resp_valid      = resp_valid_reg;
    assign resp_rdata      = resp_rdata_reg;
    assign resp_misaligned = resp_mis_reg;
    assign resp_fault      = resp_fault_reg;
    assign bus_addr        = bus_addr_reg;
    assign bus_data_out    = bus_data_reg;
    assign bus_byteen      = bus_byteen_reg;
    assign bus_mem_read    = bus_rd_reg;
    assign bus_mem_write   = bus_wr_reg;

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// ----------------------------------------------------------------------------
// tb_lsu_bus_adapter
//
// Directed bench for lsu_bus_adapter. A stimulus task runs one request and
// records what it sees on the bus and response ports. Each test task then
// compares those observations against hand-computed values.
// ----------------------------------------------------------------------------
module tb_lsu_bus_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_out;
    logic [3:0]  bus_byteen;
    logic        bus_mem_read;
    logic        bus_mem_write;
    logic [31:0] bus_data_in;
    logic        bus_ack;

    int checks   = 0;
    int failures = 0;

    // Observations from the most recent transaction
    logic        obs_ready;
    int          obs_rd;
    int          obs_wr;
    int          obs_lat;
    logic [31:0] obs_addr;
    logic [3:0]  obs_byteen;
    logic [31:0] obs_dout;
    logic [31:0] obs_rdata;
    logic        obs_mis;
    logic        obs_fault;

    lsu_bus_adapter #(.WIDTH(32), .TIMEOUT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_fault      (resp_fault),
        .bus_addr        (bus_addr),
        .bus_data_out    (bus_data_out),
        .bus_byteen      (bus_byteen),
        .bus_mem_read    (bus_mem_read),
        .bus_mem_write   (bus_mem_write),
        .bus_data_in     (bus_data_in),
        .bus_ack         (bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Runs one request, starting just after a rising edge while idle.
    // ack_after = number of wait cycles before bus_ack, -1 = never ack.
    // obs_lat = cycle (1 = first after acceptance) in which resp_valid was seen.
    task automatic do_access(input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] din, input int ack_after);
        bit done;
        obs_ready  = req_ready;
        obs_rd     = 0;
        obs_wr     = 0;
        obs_lat    = -1;
        obs_addr   = '0;
        obs_byteen = '0;
        obs_dout   = '0;
        obs_rdata  = '0;
        obs_mis    = 1'b0;
        obs_fault  = 1'b0;
        req_valid   = 1'b1;
        req_write   = wr;
        req_funct3  = f3;
        req_addr    = a;
        req_wdata   = wd;
        bus_data_in = din;
        bus_ack     = 1'b0;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            bus_ack = (ack_after >= 0) && (k == ack_after + 1);
            @(negedge clk);
            if (resp_valid) begin
                done      = 1'b1;
                obs_lat   = k;
                obs_rdata = resp_rdata;
                obs_mis   = resp_misaligned;
                obs_fault = resp_fault;
            end
            if (bus_mem_read)  obs_rd++;
            if (bus_mem_write) obs_wr++;
            if (bus_mem_read || bus_mem_write) begin
                obs_addr   = bus_addr;
                obs_byteen = bus_byteen;
                obs_dout   = bus_data_out;
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        $display("TXN wr=%0b f3=%03b addr=%08h wdata=%08h lat=%0d rd=%0d wr=%0d byteen=%04b dout=%08h rdata=%08h mis=%0b fault=%0b",
                 wr, f3, a, wd, obs_lat, obs_rd, obs_wr, obs_byteen, obs_dout,
                 obs_rdata, obs_mis, obs_fault);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if ({bus_mem_read, bus_mem_write, bus_byteen} !== 6'd0) begin failures++; $display("FAIL rst_strobes got=%b exp=0", {bus_mem_read, bus_mem_write, bus_byteen}); end
        checks++; if ({bus_addr, bus_data_out, resp_rdata} !== 96'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", {bus_addr, bus_data_out, resp_rdata}); end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("TXN reset released");
    endtask

    task automatic test_lw_aligned();
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", obs_ready); end
        checks++; if (obs_lat != 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", obs_lat); end
        checks++; if (obs_rd != 1 || obs_wr != 0) begin failures++; $display("FAIL lw_strobes got=rd%0d/wr%0d exp=rd1/wr0", obs_rd, obs_wr); end
        checks++; if (obs_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", obs_addr); end
        checks++; if (obs_byteen !== 4'b1111) begin failures++; $display("FAIL lw_byteen got=%b exp=1111", obs_byteen); end
        checks++; if (obs_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", obs_rdata); end
        checks++; if ({obs_mis, obs_fault} !== 2'b00) begin failures++; $display("FAIL lw_err got=%b exp=00", {obs_mis, obs_fault}); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL lw_resp_once got=%b%b exp=01", resp_valid, req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_loads();
        do_access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0);
        checks++; if (obs_byteen !== 4'b1000) begin failures++; $display("FAIL lb_byteen got=%b exp=1000", obs_byteen); end
        checks++; if (obs_addr !== 32'h200) begin failures++; $display("FAIL lb_addr got=%h exp=00000200", obs_addr); end
        checks++; if (obs_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); end
        do_access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0);
        checks++; if (obs_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", obs_rdata); end
        do_access(1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF1234, 0);
        checks++; if (obs_byteen !== 4'b1100) begin failures++; $display("FAIL lh_byteen got=%b exp=1100", obs_byteen); end
        checks++; if (obs_rdata !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff80ff", obs_rdata); end
        do_access(1'b0, 3'b101, 32'h0, 32'h0, 32'h80FF9234, 0);
        checks++; if (obs_byteen !== 4'b0011) begin failures++; $display("FAIL lhu_byteen got=%b exp=0011", obs_byteen); end
        checks++; if (obs_rdata !== 32'h00009234) begin failures++; $display("FAIL lhu_rdata got=%h exp=00009234", obs_rdata); end
    endtask

    task automatic test_stores();
        do_access(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h12345678, 3);
        checks++; if (obs_addr !== 32'h10) begin failures++; $display("FAIL sh_addr got=%h exp=00000010", obs_addr); end
        checks++; if (obs_byteen !== 4'b1100) begin failures++; $display("FAIL sh_byteen got=%b exp=1100", obs_byteen); end
        checks++; if (obs_dout !== 32'hABCDABCD) begin failures++; $display("FAIL sh_dout got=%h exp=abcdabcd", obs_dout); end
        checks++; if (obs_wr != 4 || obs_rd != 0) begin failures++; $display("FAIL sh_strobes got=wr%0d/rd%0d exp=wr4/rd0", obs_wr, obs_rd); end
        checks++; if (obs_lat != 5) begin failures++; $display("FAIL sh_latency got=%0d exp=5", obs_lat); end
        checks++; if (obs_rdata !== 32'h0) begin failures++; $display("FAIL sh_rdata got=%h exp=00000000", obs_rdata); end
        do_access(1'b1, 3'b000, 32'h41, 32'h1234565A, 32'h0, 0);
        checks++; if (obs_byteen !== 4'b0010) begin failures++; $display("FAIL sb_byteen got=%b exp=0010", obs_byteen); end
        checks++; if (obs_dout !== 32'h5A5A5A5A) begin failures++; $display("FAIL sb_dout got=%h exp=5a5a5a5a", obs_dout); end
    endtask

    task automatic test_errors();
        do_access(1'b0, 3'b010, 32'h102, 32'h0, 32'hFFFFFFFF, 0);
        checks++; if (obs_lat != 1) begin failures++; $display("FAIL mis_latency got=%0d exp=1", obs_lat); end
        checks++; if (obs_rd != 0 || obs_wr != 0) begin failures++; $display("FAIL mis_no_strobe got=rd%0d/wr%0d exp=0/0", obs_rd, obs_wr); end
        checks++; if ({obs_mis, obs_fault} !== 2'b10) begin failures++; $display("FAIL mis_flags got=%b exp=10", {obs_mis, obs_fault}); end
        checks++; if (obs_rdata !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=00000000", obs_rdata); end
        do_access(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
        checks++; if ({obs_mis, obs_fault} !== 2'b10) begin failures++; $display("FAIL lh_mis_flags got=%b exp=10", {obs_mis, obs_fault}); end
        do_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        checks++; if ({obs_mis, obs_fault} !== 2'b01) begin failures++; $display("FAIL ld011_flags got=%b exp=01", {obs_mis, obs_fault}); end
        checks++; if (obs_lat != 1 || obs_rd != 0) begin failures++; $display("FAIL ld011_timing got=lat%0d/rd%0d exp=lat1/rd0", obs_lat, obs_rd); end
        do_access(1'b0, 3'b111, 32'h101, 32'h0, 32'h0, 0);
        checks++; if ({obs_mis, obs_fault} !== 2'b01) begin failures++; $display("FAIL fault_prio got=%b exp=01", {obs_mis, obs_fault}); end
        do_access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        checks++; if ({obs_mis, obs_fault} !== 2'b01 || obs_wr != 0) begin failures++; $display("FAIL st100_fault got=%b/wr%0d exp=01/wr0", {obs_mis, obs_fault}, obs_wr); end
    endtask

    task automatic test_timeout_back_to_back();
        do_access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, -1);
        checks++; if (obs_wr != 16) begin failures++; $display("FAIL to_strobe_cycles got=%0d exp=16", obs_wr); end
        checks++; if (obs_lat != 17) begin failures++; $display("FAIL to_latency got=%0d exp=17", obs_lat); end
        checks++; if ({obs_mis, obs_fault} !== 2'b01) begin failures++; $display("FAIL to_flags got=%b exp=01", {obs_mis, obs_fault}); end
        checks++; if (obs_dout !== 32'hCAFEF00D) begin failures++; $display("FAIL to_dout got=%h exp=cafef00d", obs_dout); end
        do_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h01020304, 0);
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", obs_ready); end
        checks++; if (obs_lat != 2 || obs_rdata !== 32'h01020304) begin failures++; $display("FAIL b2b_resp got=lat%0d/%h exp=lat2/01020304", obs_lat, obs_rdata); end
    endtask

    task automatic test_reset_mid_bus();
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_funct3  = 3'b010;
        req_addr    = 32'h400;
        bus_data_in = 32'h55555555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus_mem_read !== 1'b1) begin failures++; $display("FAIL rmb_strobe_before got=%b exp=1", bus_mem_read); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({bus_mem_read, bus_byteen, bus_addr} !== 37'd0) begin failures++; $display("FAIL rmb_async_clear got=%h exp=0", {bus_mem_read, bus_byteen, bus_addr}); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({resp_valid, req_ready, bus_mem_read} !== 3'b010) begin failures++; $display("FAIL rmb_after_ack got=%b exp=010", {resp_valid, req_ready, bus_mem_read}); end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        $display("TXN reset during bus phase");
    endtask

    initial begin
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_funct3  = 3'd0;
        req_addr    = '0;
        req_wdata   = '0;
        bus_data_in = '0;
        bus_ack     = 1'b0;
        test_reset();
        test_lw_aligned();
        test_byte_loads();
        test_stores();
        test_errors();
        test_timeout_back_to_back();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store front end between the multicycle core and the memory bus.
- Accepts one memory request at a time from the core's memory-access state.
- Generates word-aligned bus address, byte enables, lane-replicated write data and read/write strobes, then waits for bus acknowledge.
- Returns aligned, sign/zero-extended load data, or a misalignment or fault indication.

Parameters:
- WIDTH, 32, data/address width; the byte-lane logic requires WIDTH = 32.
- TIMEOUT, 16, number of BUS-state cycles without bus_ack before a fault response; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  adapter can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data (rs2).
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  WIDTH  extended load result; 0 for stores and errors.
- resp_misaligned  out  1  address misaligned for the access size; valid with resp_valid.
- resp_fault  out  1  illegal funct3 or bus timeout; valid with resp_valid.
- bus_addr  out  WIDTH  word address, {req_addr[31:2], 2'b00}.
- bus_data_out  out  WIDTH  store data, replicated across lanes.
- bus_byteen  out  4  byte-lane enables.
- bus_mem_read  out  1  read strobe.
- bus_mem_write  out  1  write strobe.
- bus_data_in  in  WIDTH  read data from bus.
- bus_ack  in  1  bus completes the current access.

Behaviour:
- Reset values: state IDLE, req_ready = 1, all other outputs 0, timeout counter 0. Reset takes effect immediately.
- FSM states: IDLE, BUS, RESP.
- IDLE, no req_valid: stay in IDLE.
- IDLE, req_valid: latch write, funct3, addr and wdata.
  - Illegal funct3 → RESP with fault. Illegal for loads: 011, 110, 111. Illegal for stores: anything other than 000, 001, 010.
  - Misaligned address → RESP with misaligned. Misaligned means: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Otherwise → BUS with counter cleared.
  - No bus strobe is ever raised for an illegal or misaligned request.
  - If both conditions hold, fault takes priority; misaligned is not reported.
- Byte enables: byte access = 4'b0001 << addr[1:0]; half access = 4'b0011 << addr[1:0]; word access = 4'b1111.
- Store data lanes: SB drives {4{wdata[7:0]}}; SH drives {2{wdata[15:0]}}; SW drives wdata.
- BUS state:
  - Outputs are registered and stable for the whole state. bus_mem_read = !write, bus_mem_write = write.
  - Counter increments every cycle without bus_ack.
  - bus_ack = 1: capture bus_data_in and go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: go to RESP with fault, rdata = 0.
  - Strobes, byteen, addr and wdata return to 0 on BUS exit.
- Load extension: shifted = captured_data >> (8*addr[1:0]).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0].
  - LW: whole word.
- RESP state: resp_valid = 1 for exactly one cycle with rdata/misaligned/fault; next state IDLE. Outside RESP, resp_* = 0.
- Latency:
  - Aligned access with bus_ack in the first BUS cycle: request accepted at edge N, strobes high during cycle N+1, resp_valid during cycle N+2.
  - Each wait cycle adds 1.
  - Error requests: resp_valid in the cycle after acceptance.
- Back-to-back: a new request is accepted one cycle after resp_valid (IDLE re-entered).
- bus_ack in IDLE or RESP is ignored. req_valid outside IDLE is ignored, because req_ready = 0.
- Reset mid-BUS: strobes drop asynchronously, no response is produced, and a later bus_ack is ignored.

Test Plan:
- Aligned LW addr 0x100, bus_data_in 0xDEADBEEF, ack first cycle → bus_addr 0x100, byteen 1111, read strobe for 1 cycle; resp_valid 2 cycles after acceptance, rdata 0xDEADBEEF.
- LB addr 0x203 / LBU addr 0x203, bus data 0x80FF1234 → byteen 1000; LB rdata 0xFFFFFF80, LBU rdata 0x00000080.
- SH addr 0x12, wdata 0x0000ABCD, ack after 3 wait cycles → bus_addr 0x10, byteen 1100, bus_data_out 0xABCDABCD, write strobe for 4 cycles; resp rdata 0.
- LW addr 0x102 → no bus strobe, next cycle resp_valid with misaligned = 1; funct3 = 3'b011 load → fault = 1, misaligned = 0.
- SW with bus_ack never asserted, TIMEOUT = 16 → write strobe for 16 cycles, then resp_valid with fault = 1; next request accepted the cycle after.
- Assert reset during BUS cycle 2 of a load, then pulse bus_ack → strobes 0 immediately, no resp_valid, req_ready = 1 after reset release.
